// File: rtl/hourly_logger.sv
// Counts arriving cars and, at each end-of-hour tick, writes the cumulative total to RAM at the hour's address.
// Latency: wr_en/wr_addr/wr_data appear one clk after hour_tick; all outputs are registered.
// No backpressure: the RAM accepts every write; a tick arriving while busy or done is dropped and flagged on overrun.
module hourly_logger #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 4,
  parameter int NUM_HOURS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              car_in_i,
  input  logic              hour_tick_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [ADDR_W-1:0] hour_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W-1:0] LAST_HOUR = ADDR_W'(NUM_HOURS - 1);
  localparam logic [DATA_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] total_q;
  logic [DATA_W-1:0] total_d;
  logic [ADDR_W-1:0] hour_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;
  logic              overrun_q;

  // Saturating car total; counting continues through WRITE so no car is lost, and freezes once the day is done.
  always_comb begin
    total_d = total_q;
    if (state_q != S_DONE && car_in_i && total_q != TOTAL_MAX) begin
      total_d = total_q + 1'b1;
    end
  end

  // Logging FSM with registered write strobe, address, data, done and overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_COUNT;
      total_q   <= '0;
      hour_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      total_q   <= total_d;
      wr_en_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        S_COUNT: begin
          if (hour_tick_i) begin
            // Snapshot uses total_d so a car in the tick cycle belongs to the closing hour.
            state_q   <= S_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= hour_q;
            wr_data_q <= total_d;
          end
        end
        S_WRITE: begin
          overrun_q <= hour_tick_i;
          if (hour_q == LAST_HOUR) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_COUNT;
            hour_q  <= hour_q + 1'b1;
          end
        end
        S_DONE: begin
          overrun_q <= hour_tick_i;
        end
        default: begin
          state_q <= S_COUNT;
        end
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign hour_o    = hour_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule
